alu_share_arbiter: RTL and testbench

- Shares the single execute-stage ALU between two requesters. Slot 0 is the main pipeline; slot 1 is the auxiliary issue path (LL/SC retry, or a second issue slot).
- Grants requesters round-robin and drives the ALU input, which the ALU evaluates combinationally.
- Captures the ALU result in a one-entry response buffer with valid/ready back-pressure.
- Watches the MTC0 pass/done code to halt issue on DONE and flag FAIL.

---
 rtl/alu_share_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares the single execute-stage ALU between two requesters (slot 0 = main
//   pipeline, slot 1 = auxiliary issue path). Requests are granted round-robin,
//   the granted slot's fields drive the combinational ALU, and the ALU outputs
//   are captured in a one-entry response buffer with valid/ready handshake.
//   The MTC0 pass/done code of accepted ops halts issue (DONE) or raises a
//   sticky failure flag (FAIL).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid / req_ready      per-slot request handshake (req_ready one-hot or zero)
//   reqN_alu_ctl/op1/op2/id    per-slot operation fields
//   alu_valid/ctl/op1/op2/id   drive to the ALU input
//   alu_result/branch_taken/pass_code  combinational ALU outputs
//   rsp_valid / rsp_ready      response buffer handshake
//   rsp_slot/result/branch_taken/id    buffered response contents
//   halted, fail_seen          sticky status flags
module alu_share_arbiter #(
    parameter int unsigned ALUCTL_W = 5,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ID_W     = 20,
    parameter int unsigned CODE_W   = 2,
    parameter logic [CODE_W-1:0] MTC0_FAIL = 2'd2,
    parameter logic [CODE_W-1:0] MTC0_DONE = 2'd3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [ALUCTL_W-1:0] req0_alu_ctl,
    input  logic [DATA_W-1:0]   req0_op1,
    input  logic [DATA_W-1:0]   req0_op2,
    input  logic [ID_W-1:0]     req0_id,
    input  logic [ALUCTL_W-1:0] req1_alu_ctl,
    input  logic [DATA_W-1:0]   req1_op1,
    input  logic [DATA_W-1:0]   req1_op2,
    input  logic [ID_W-1:0]     req1_id,
    output logic                alu_valid,
    output logic [ALUCTL_W-1:0] alu_ctl,
    output logic [DATA_W-1:0]   alu_op1,
    output logic [DATA_W-1:0]   alu_op2,
    output logic [ID_W-1:0]     alu_id,
    input  logic [DATA_W-1:0]   alu_result,
    input  logic                alu_branch_taken,
    input  logic [CODE_W-1:0]   alu_pass_code,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_slot,
    output logic [DATA_W-1:0]   rsp_result,
    output logic                rsp_branch_taken,
    output logic [ID_W-1:0]     rsp_id,
    output logic                halted,
    output logic                fail_seen
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic                rr_ptr_q, rr_ptr_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_slot_q, rsp_slot_d;
    logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
    logic                rsp_branch_q, rsp_branch_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic                halted_q, halted_d;
    logic                fail_seen_q, fail_seen_d;

    logic                grant_vld_s;
    logic                grant_slot_s;
    logic                can_issue_s;
    logic                accept_s;

    // Round-robin grant: a lone requester wins outright, a contest goes to rr_ptr.
    always_comb begin
        grant_vld_s  = 1'b0;
        grant_slot_s = 1'b0;
        case (req_valid)
            2'b01: begin
                grant_vld_s  = 1'b1;
                grant_slot_s = 1'b0;
            end
            2'b10: begin
                grant_vld_s  = 1'b1;
                grant_slot_s = 1'b1;
            end
            2'b11: begin
                grant_vld_s  = 1'b1;
                grant_slot_s = rr_ptr_q;
            end
            default: begin
                grant_vld_s  = 1'b0;
                grant_slot_s = 1'b0;
            end
        endcase
    end

    // Issue is possible in RUN when the buffer is empty or drains this cycle,
    // which lets a drain and a new accept overlap for one op per cycle.
    always_comb begin
        can_issue_s = (state_q == ST_RUN) && (!rsp_valid_q || rsp_ready);
        accept_s    = grant_vld_s && can_issue_s;
    end

    // Handshake and ALU drive; the ALU sees a NOP with zero fields unless an op issues.
    always_comb begin
        req_ready = 2'b00;
        alu_valid = 1'b0;
        alu_ctl   = '0;
        alu_op1   = '0;
        alu_op2   = '0;
        alu_id    = '0;
        if (accept_s) begin
            alu_valid = 1'b1;
            if (grant_slot_s) begin
                req_ready = 2'b10;
                alu_ctl   = req1_alu_ctl;
                alu_op1   = req1_op1;
                alu_op2   = req1_op2;
                alu_id    = req1_id;
            end else begin
                req_ready = 2'b01;
                alu_ctl   = req0_alu_ctl;
                alu_op1   = req0_op1;
                alu_op2   = req0_op2;
                alu_id    = req0_id;
            end
        end else begin
            req_ready = 2'b00;
        end
    end

    // Next state: load buffer and steer pointer on accept, otherwise drain or hold.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_slot_d   = rsp_slot_q;
        rsp_result_d = rsp_result_q;
        rsp_branch_d = rsp_branch_q;
        rsp_id_d     = rsp_id_q;
        halted_d     = halted_q;
        fail_seen_d  = fail_seen_q;
        if (accept_s) begin
            rsp_valid_d  = 1'b1;
            rsp_slot_d   = grant_slot_s;
            rsp_result_d = alu_result;
            rsp_branch_d = alu_branch_taken;
            rsp_id_d     = alu_id;
            rr_ptr_d     = ~grant_slot_s;
            if (alu_pass_code == MTC0_DONE) begin
                state_d  = ST_HALT;
                halted_d = 1'b1;
            end else if (alu_pass_code == MTC0_FAIL) begin
                fail_seen_d = 1'b1;
            end else begin
                fail_seen_d = fail_seen_q;
            end
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end else begin
            rsp_valid_d = rsp_valid_q;
        end
    end

    // State and response registers; everything clears on rst_n low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            rr_ptr_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_slot_q   <= 1'b0;
            rsp_result_q <= '0;
            rsp_branch_q <= 1'b0;
            rsp_id_q     <= '0;
            halted_q     <= 1'b0;
            fail_seen_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_slot_q   <= rsp_slot_d;
            rsp_result_q <= rsp_result_d;
            rsp_branch_q <= rsp_branch_d;
            rsp_id_q     <= rsp_id_d;
            halted_q     <= halted_d;
            fail_seen_q  <= fail_seen_d;
        end
    end

    assign rsp_valid        = rsp_valid_q;
    assign rsp_slot         = rsp_slot_q;
    assign rsp_result       = rsp_result_q;
    assign rsp_branch_taken = rsp_branch_q;
    assign rsp_id           = rsp_id_q;
    assign halted           = halted_q;
    assign fail_seen        = fail_seen_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed testbench for alu_share_arbiter with a small combinational ALU model.
module tb_alu_share_arbiter;

    localparam logic [4:0] C_NOP  = 5'd0;
    localparam logic [4:0] C_ADD  = 5'd1;
    localparam logic [4:0] C_SUB  = 5'd2;
    localparam logic [4:0] C_OR   = 5'd3;
    localparam logic [4:0] C_XOR  = 5'd4;
    localparam logic [4:0] C_BEQ  = 5'd5;
    localparam logic [4:0] C_MTC0 = 5'd6;
    localparam logic [1:0] P_NOOP = 2'd0;
    localparam logic [1:0] P_FAIL = 2'd2;
    localparam logic [1:0] P_DONE = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [4:0]  req0_alu_ctl, req1_alu_ctl;
    logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
    logic [19:0] req0_id, req1_id;
    logic        alu_valid;
    logic [4:0]  alu_ctl;
    logic [31:0] alu_op1, alu_op2;
    logic [19:0] alu_id;
    logic [31:0] alu_result;
    logic        alu_branch_taken;
    logic [1:0]  alu_pass_code;
    logic        rsp_valid, rsp_ready, rsp_slot, rsp_branch_taken;
    logic [31:0] rsp_result;
    logic [19:0] rsp_id;
    logic        halted, fail_seen;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_share_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_alu_ctl(req0_alu_ctl), .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_id(req0_id),
        .req1_alu_ctl(req1_alu_ctl), .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_id(req1_id),
        .alu_valid(alu_valid), .alu_ctl(alu_ctl), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_id(alu_id),
        .alu_result(alu_result), .alu_branch_taken(alu_branch_taken), .alu_pass_code(alu_pass_code),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_slot(rsp_slot), .rsp_result(rsp_result),
        .rsp_branch_taken(rsp_branch_taken), .rsp_id(rsp_id),
        .halted(halted), .fail_seen(fail_seen)
    );

    // ALU environment model: MTC0 takes its pass code from op1[1:0] and returns op2.
    always_comb begin
        alu_result       = 32'd0;
        alu_branch_taken = 1'b0;
        alu_pass_code    = P_NOOP;
        case (alu_ctl)
            C_ADD:   alu_result = alu_op1 + alu_op2;
            C_SUB:   alu_result = alu_op1 - alu_op2;
            C_OR:    alu_result = alu_op1 | alu_op2;
            C_XOR:   alu_result = alu_op1 ^ alu_op2;
            C_BEQ: begin
                alu_result       = alu_op1 - alu_op2;
                alu_branch_taken = (alu_op1 == alu_op2);
            end
            C_MTC0: begin
                alu_result    = alu_op2;
                alu_pass_code = alu_op1[1:0];
            end
            default: alu_result = 32'd0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b, input logic [19:0] id);
        req0_alu_ctl = c; req0_op1 = a; req0_op2 = b; req0_id = id;
    endtask

    task automatic set1(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b, input logic [19:0] id);
        req1_alu_ctl = c; req1_op1 = a; req1_op2 = b; req1_id = id;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
        set0(C_NOP, 32'd0, 32'd0, 20'd0);
        set1(C_NOP, 32'd0, 32'd0, 20'd0);
        tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        checks++; if (rsp_result !== 32'd0) begin errors++; $display("FAIL reset_rsp_result got %h want 0", rsp_result); end
        checks++; if ({halted, fail_seen} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {halted, fail_seen}); end
        checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL reset_alu_valid got %b want 0", alu_valid); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_op();
        rsp_ready = 1'b1; req_valid = 2'b01;
        set0(C_ADD, 32'd5, 32'd7, 20'h00a01);
        @(negedge clk);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_req_ready got %b want 01", req_ready); end
        checks++; if (alu_valid !== 1'b1 || alu_op2 !== 32'd7) begin errors++; $display("FAIL single_alu_drive got v=%b op2=%h want v=1 op2=7", alu_valid, alu_op2); end
        tick();
        req_valid = 2'b00;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid got %b want 1", rsp_valid); end
        checks++; if (rsp_result !== 32'd12) begin errors++; $display("FAIL single_rsp_result got %0d want 12", rsp_result); end
        checks++; if (rsp_slot !== 1'b0 || rsp_id !== 20'h00a01) begin errors++; $display("FAIL single_rsp_slot_id got %b/%h want 0/00a01", rsp_slot, rsp_id); end
        tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b want 0", rsp_valid); end
    endtask

    // Pointer is at slot 1 after the slot-0 op, so grants run 1,0,1,0.
    task automatic test_contention();
        logic [3:0] exp_slots;
        exp_slots = 4'b0101;
        rsp_ready = 1'b1; req_valid = 2'b11;
        set0(C_SUB, 32'd9, 32'd4, 20'h00b00);
        set1(C_OR, 32'h000000f0, 32'h0000000f, 20'h00b01);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== (exp_slots[i] ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL contention_grant[%0d] got %b want slot %0d", i, req_ready, exp_slots[i]);
            end
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_slot !== exp_slots[i] || rsp_result !== (exp_slots[i] ? 32'h000000ff : 32'd5)) begin
                errors++; $display("FAIL contention_rsp[%0d] got v=%b slot=%b res=%h want slot %0d", i, rsp_valid, rsp_slot, rsp_result, exp_slots[i]);
            end
        end
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_back_pressure();
        rsp_ready = 1'b0; req_valid = 2'b10;
        set1(C_BEQ, 32'd3, 32'd3, 20'h00c01);
        @(negedge clk);
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_accept got %b want 10", req_ready); end
        tick();
        req_valid = 2'b01;
        set0(C_ADD, 32'd1, 32'd2, 20'h00c00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_stall[%0d] got %b want 00", i, req_ready); end
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_branch_taken !== 1'b1 || rsp_slot !== 1'b1 || rsp_id !== 20'h00c01) begin
                errors++; $display("FAIL bp_hold[%0d] got v=%b br=%b slot=%b id=%h want 1/1/1/00c01", i, rsp_valid, rsp_branch_taken, rsp_slot, rsp_id);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_release got %b want 01", req_ready); end
        tick();
        req_valid = 2'b00;
        checks++;
        if (rsp_slot !== 1'b0 || rsp_result !== 32'd3 || rsp_branch_taken !== 1'b0) begin
            errors++; $display("FAIL bp_next_rsp got slot=%b res=%0d br=%b want 0/3/0", rsp_slot, rsp_result, rsp_branch_taken);
        end
        tick();
    endtask

    task automatic test_fail_done();
        rsp_ready = 1'b1; req_valid = 2'b01;
        set0(C_MTC0, {30'd0, P_FAIL}, 32'h00000011, 20'h00d00);
        tick();
        checks++; if (fail_seen !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL fail_flag got fail=%b halt=%b want 1/0", fail_seen, halted); end
        checks++; if (rsp_result !== 32'h00000011) begin errors++; $display("FAIL fail_rsp got %h want 00000011", rsp_result); end
        set0(C_MTC0, {30'd0, P_DONE}, 32'h00000022, 20'h00d01);
        @(negedge clk);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL fail_continues got %b want 01", req_ready); end
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'h00000022) begin errors++; $display("FAIL done_rsp got v=%b res=%h want 1/00000022", rsp_valid, rsp_result); end
        checks++; if (halted !== 1'b1 || fail_seen !== 1'b1) begin errors++; $display("FAIL done_halted got halt=%b fail=%b want 1/1", halted, fail_seen); end
        req_valid = 2'b11;
        set1(C_ADD, 32'd1, 32'd1, 20'h00d02);
        @(negedge clk);
        checks++; if (req_ready !== 2'b00 || alu_valid !== 1'b0) begin errors++; $display("FAIL halt_no_issue got rdy=%b alu_v=%b want 00/0", req_ready, alu_valid); end
        tick();
        checks++; if (rsp_valid !== 1'b0 || halted !== 1'b1) begin errors++; $display("FAIL halt_drain got v=%b halt=%b want 0/1", rsp_valid, halted); end
        req_valid = 2'b00;
    endtask

    task automatic test_reset_mid_op();
        rst_n = 1'b0;
        #1;
        checks++; if (halted !== 1'b0 || fail_seen !== 1'b0) begin errors++; $display("FAIL rst_clears_halt got halt=%b fail=%b want 0/0", halted, fail_seen); end
        rst_n = 1'b1;
        rsp_ready = 1'b1; req_valid = 2'b10;
        set1(C_XOR, 32'h000000a5, 32'h000000ff, 20'h00e01);
        @(negedge clk);
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rstmid_xor_grant got %b want 10", req_ready); end
        tick();
        checks++; if (rsp_result !== 32'h0000005a || rsp_slot !== 1'b1) begin errors++; $display("FAIL rstmid_xor_rsp got %h/%b want 0000005a/1", rsp_result, rsp_slot); end
        req_valid = 2'b01;
        set0(C_MTC0, {30'd0, P_FAIL}, 32'h00000033, 20'h00e00);
        tick();
        req_valid = 2'b00; rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || fail_seen !== 1'b1 || rsp_result !== 32'h00000033) begin errors++; $display("FAIL rstmid_pending got v=%b fail=%b res=%h want 1/1/00000033", rsp_valid, fail_seen, rsp_result); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || fail_seen !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL rstmid_async got v=%b fail=%b halt=%b want 0/0/0", rsp_valid, fail_seen, halted); end
        rst_n = 1'b1;
        rsp_ready = 1'b1; req_valid = 2'b11;
        set0(C_ADD, 32'd2, 32'd2, 20'h00e02);
        @(negedge clk);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rstmid_rr_reset got %b want 01", req_ready); end
        tick();
        checks++; if (rsp_slot !== 1'b0 || rsp_result !== 32'd4) begin errors++; $display("FAIL rstmid_first_rsp got %b/%0d want 0/4", rsp_slot, rsp_result); end
        req_valid = 2'b00;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_contention();
        test_back_pressure();
        test_fail_done();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
